// File: rtl/dcf_tick_sync.sv
`default_nettype none
// ============================================================================
//  Module   : dcf_tick_sync
//  Purpose  : Owns the 1 Hz seconds-enable prescaler, phase-aligns it to the
//             DCF77 second pulse, tracks lock and flags the minute mark
//             (the missing 59th-second pulse).
//  Options  : DCF_PHASE_ERR_EN adds the signed phase_err output.
//  Revision : 1.0 - initial release
// ============================================================================
module dcf_tick_sync #(
    parameter int CLK_HZ     = 10000000,
    parameter int TOL        = 100000,
    parameter int LOCK_COUNT = 3,
    parameter int BAD_LIMIT  = 4,
    parameter int MISS_LIMIT = 3
) (
    input  logic               clk10,
    input  logic               reset,
    input  logic               dcf_in,
    output logic               tick,
    output logic               locked,
    output logic               minute_mark
`ifdef DCF_PHASE_ERR_EN
    ,
    output logic signed [26:0] phase_err
`endif
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [25:0] C_LAST   = 26'(CLK_HZ - 1);
    localparam logic [25:0] C_HALF   = 26'(CLK_HZ / 2);
    localparam logic [25:0] C_TOL    = 26'(TOL);
    localparam logic [25:0] C_WIN_LO = 26'(CLK_HZ - TOL);
    localparam logic [7:0]  C_LOCK   = 8'(LOCK_COUNT);
    localparam logic [7:0]  C_BAD    = 8'(BAD_LIMIT);
    localparam logic [7:0]  C_MISS   = 8'(MISS_LIMIT);

    logic        sync1_q, sync2_q, sync3_q, edge_q;
    logic [25:0] cnt_q, cnt_d;
    logic        tick_q, tick_d;
    logic        locked_q;
    logic        seen_q, seen_d;
    state_t      state_q, state_d;
    logic [7:0]  good_q, good_d;
    logic [7:0]  bad_q, bad_d;
    logic [7:0]  miss_q, miss_d;
    logic        in_window;
    logic        win_close;
    logic        resync;

    // Bring the asynchronous pin into clk10 and register a one-cycle rising-edge strobe
    always_ff @(posedge clk10 or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= dcf_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            edge_q  <= sync2_q & ~sync3_q;
        end
    end

    // The acceptance window straddles the wrap point; it closes at cnt==TOL
    assign in_window = (cnt_q >= C_WIN_LO) || (cnt_q < C_TOL);
    assign win_close = (cnt_q == C_TOL);

    // Lock state machine: decides whether an edge is accepted and tracks good/bad/miss runs
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        miss_d  = miss_q;
        resync  = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (edge_q) begin
                    resync  = 1'b1;
                    good_d  = 8'd1;
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (edge_q) begin
                    resync = 1'b1;
                    if (in_window) begin
                        good_d = good_q + 8'd1;
                        if (good_q + 8'd1 == C_LOCK) begin
                            state_d = ST_LOCKED;
                            bad_d   = '0;
                            miss_d  = '0;
                        end
                    end else begin
                        good_d = 8'd1;
                    end
                end
            end
            ST_LOCKED: begin
                if (edge_q) begin
                    if (in_window) begin
                        resync = 1'b1;
                        bad_d  = '0;
                        miss_d = '0;
                    end else begin
                        // Stray edges never move the prescaler once locked
                        bad_d = bad_q + 8'd1;
                        if (bad_q + 8'd1 == C_BAD) begin
                            state_d = ST_HUNT;
                        end
                    end
                end
                if (win_close && !seen_q) begin
                    miss_d = miss_q + 8'd1;
                    if (miss_q + 8'd1 == C_MISS) begin
                        state_d = ST_HUNT;
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    // Prescaler step: a resync overrides the natural wrap so only one tick is issued
    always_comb begin
        cnt_d  = (cnt_q == C_LAST) ? '0 : cnt_q + 26'd1;
        tick_d = (cnt_q == C_LAST);
        seen_d = seen_q | (resync & in_window);
        if (resync) begin
            cnt_d  = 26'd1;
            tick_d = (cnt_q > C_HALF);
        end
        if (win_close) begin
            seen_d = 1'b0;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk10 or posedge reset) begin
        if (reset) begin
            state_q  <= ST_HUNT;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            locked_q <= 1'b0;
            seen_q   <= 1'b0;
            good_q   <= '0;
            bad_q    <= '0;
            miss_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            locked_q <= (state_q == ST_LOCKED);
            seen_q   <= seen_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            miss_q   <= miss_d;
        end
    end

    assign tick        = tick_q;
    assign locked      = locked_q;
    // Only the first empty window of a run is the minute mark
    assign minute_mark = (state_q == ST_LOCKED) && win_close && !seen_q && (miss_q == '0);

`ifdef DCF_PHASE_ERR_EN
    logic        [26:0] off_w;
    logic signed [26:0] perr_q;

    assign off_w = (cnt_q < C_TOL) ? {1'b0, cnt_q} : ({1'b0, cnt_q} - 27'(CLK_HZ));

    // Capture the signed arrival offset of each accepted edge; negative means early
    always_ff @(posedge clk10 or posedge reset) begin
        if (reset) begin
            perr_q <= '0;
        end else if (resync) begin
            perr_q <= $signed(off_w);
        end
    end

    assign phase_err = perr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcf_tick_sync.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcf_tick_sync
//  Purpose  : Self-checking bench for dcf_tick_sync with a cycle-level
//             behavioural model and directed plus randomized pin stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dcf_tick_sync;

    localparam int CLK_HZ     = 1000;
    localparam int TOL        = 50;
    localparam int LOCK_COUNT = 3;
    localparam int BAD_LIMIT  = 4;
    localparam int MISS_LIMIT = 3;
    localparam int M_HUNT     = 0;
    localparam int M_TRACK    = 1;
    localparam int M_LOCKED   = 2;

    logic clk10  = 1'b0;
    logic reset  = 1'b1;
    logic dcf_in = 1'b0;
    logic tick, locked, minute_mark;
`ifdef DCF_PHASE_ERR_EN
    logic signed [26:0] phase_err;
`endif

    int checks = 0;
    int errors = 0;

    dcf_tick_sync #(
        .CLK_HZ    (CLK_HZ),
        .TOL       (TOL),
        .LOCK_COUNT(LOCK_COUNT),
        .BAD_LIMIT (BAD_LIMIT),
        .MISS_LIMIT(MISS_LIMIT)
    ) dut (
        .clk10      (clk10),
        .reset      (reset),
        .dcf_in     (dcf_in),
        .tick       (tick),
        .locked     (locked),
        .minute_mark(minute_mark)
`ifdef DCF_PHASE_ERR_EN
        ,
        .phase_err  (phase_err)
`endif
    );

    always #5 clk10 = ~clk10;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_cnt  = 0;
    int m_mode = M_HUNT;
    int m_good = 0, m_bad = 0, m_miss = 0;
    bit m_seen = 0;
    bit smp [4] = '{0, 0, 0, 0};   // pin samples at the last four clock edges
    bit e_tick = 0, e_locked = 0, e_mm = 0;
    int e_perr = 0;

    always @(posedge clk10 or posedge reset) begin : model
        bit ev, inwin, close, acc;
        int old, nmode;
        if (reset) begin
            m_cnt = 0; m_mode = M_HUNT; m_good = 0; m_bad = 0; m_miss = 0; m_seen = 0;
            smp = '{0, 0, 0, 0};
            e_tick = 0; e_locked = 0; e_mm = 0; e_perr = 0;
        end else begin
            // A pin rise sampled three edges ago is acted on now
            ev = smp[2] && !smp[3];
            smp[3] = smp[2]; smp[2] = smp[1]; smp[1] = smp[0]; smp[0] = dcf_in;
            old   = m_cnt;
            inwin = (old >= CLK_HZ - TOL) || (old < TOL);
            close = (old == TOL);
            acc   = 0;
            nmode = m_mode;
            e_locked = (m_mode == M_LOCKED);
            if (ev) begin
                if (m_mode == M_HUNT) begin
                    acc = 1; m_good = 1; nmode = M_TRACK;
                end else if (m_mode == M_TRACK) begin
                    acc = 1;
                    if (inwin) begin
                        m_good++;
                        if (m_good == LOCK_COUNT) begin nmode = M_LOCKED; m_bad = 0; m_miss = 0; end
                    end else m_good = 1;
                end else begin
                    if (inwin) begin acc = 1; m_bad = 0; m_miss = 0; end
                    else begin m_bad++; if (m_bad == BAD_LIMIT) nmode = M_HUNT; end
                end
            end
            if (m_mode == M_LOCKED && close && !m_seen) begin
                m_miss++;
                if (m_miss == MISS_LIMIT) nmode = M_HUNT;
            end
            if (close) m_seen = 0;
            else if (acc && inwin) m_seen = 1;
            if (acc) begin
                e_tick = (old > CLK_HZ / 2);
                e_perr = (old < TOL) ? old : old - CLK_HZ;
                m_cnt  = 1;
            end else begin
                e_tick = (old == CLK_HZ - 1);
                m_cnt  = (old + 1) % CLK_HZ;
            end
            m_mode = nmode;
            e_mm = (m_mode == M_LOCKED) && (m_cnt == TOL) && !m_seen && (m_miss == 0);
        end
    end

    // ---------------- per-cycle compare ----------------
    int cyc = 0, last_tick = -1, tick_gap = 0, tick_cnt = 0, mm_cnt = 0;

    always @(negedge clk10) begin
        cyc++;
        if (tick) begin
            if (last_tick >= 0) tick_gap = cyc - last_tick;
            last_tick = cyc;
            tick_cnt++;
        end
        if (minute_mark) mm_cnt++;
        check("tick", tick, e_tick);
        check("locked", locked, e_locked);
        check("minute_mark", minute_mark, e_mm);
`ifdef DCF_PHASE_ERR_EN
        check("phase_err", phase_err, e_perr);
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk10);
    endtask

    // One "second" of pin activity: optional 100-cycle main pulse plus short glitches
    task automatic gen_sec(input bit main, input int period, input int ng, input int gstart, input int gstep);
        for (int k = 0; k < period; k++) begin
            bit v;
            v = main && (k < 100);
            for (int g = 0; g < ng; g++)
                if (k >= gstart + g * gstep && k < gstart + g * gstep + 10) v = 1;
            dcf_in = v;
            @(negedge clk10);
        end
        dcf_in = 1'b0;
    endtask

    task automatic wait_cnt(input int target);
        bit found = 0;
        for (int k = 0; k < 3 * CLK_HZ && !found; k++) begin
            @(negedge clk10);
            if (m_cnt == target) found = 1;
        end
        check("wait_cnt_bound", found, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int tt[$];
        bit any_locked, any_mm;
        int t0, mm0, first, nt;

        // Reset state
        cycles(3);
        check("rst_tick", tick, 0);
        check("rst_locked", locked, 0);
        check("rst_mm", minute_mark, 0);
        reset = 1'b0;

        // Free-run with no pin activity
        any_locked = 0; any_mm = 0;
        for (int k = 1; k <= 3005; k++) begin
            @(negedge clk10);
            if (tick) tt.push_back(k);
            any_locked |= locked;
            any_mm |= minute_mark;
        end
        check("freerun_tick_count", tt.size(), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("freerun_tick%0d", i), (tt.size() > i) ? tt[i] : -1, (i + 1) * CLK_HZ);
        check("freerun_locked", any_locked, 0);
        check("freerun_mm", any_mm, 0);

        // Acquire from phase 370
        wait_cnt(370 - 3);
        gen_sec(1, 1000, 0, 0, 0);
        gen_sec(1, 1000, 0, 0, 0);
        #1 check("locked_after2", locked, 0);
        gen_sec(1, 1000, 0, 0, 0);
        #1 check("locked_after3", locked, 1);
        gen_sec(1, 1000, 0, 0, 0);
        gen_sec(1, 1000, 0, 0, 0);
        #1 check("lock_tick_gap", tick_gap, CLK_HZ);

        // Omitted pulse gives one minute mark and keeps lock
        mm0 = mm_cnt;
        gen_sec(0, 1000, 0, 0, 0);
        #1 check("minute_mark_once", mm_cnt - mm0, 1);
        check("locked_after_gap", locked, 1);
        gen_sec(1, 1000, 0, 0, 0);
        gen_sec(1, 1000, 0, 0, 0);
        #1 check("minute_mark_cleared", mm_cnt - mm0, 1);

        // Single glitch per second: good pulses keep clearing the bad run
        for (int s = 0; s < 4; s++) gen_sec(1, 1000, 1, 500, 0);
        #1 check("glitch_tick_gap", tick_gap, CLK_HZ);
        check("glitch_locked", locked, 1);
        // Four glitches in one second exhaust the bad budget
        gen_sec(1, 1000, 4, 200, 200);
        #1 check("glitch4_unlock", locked, 0);

        // Randomized seconds with jitter, drops and glitches
        for (int s = 0; s < 20; s++) begin
            int r, per, ng;
            r   = $urandom_range(0, 9);
            per = (r == 1) ? 1000 + int'($urandom_range(100, 400))
                           : 1000 + int'($urandom_range(0, 140)) - 70;
            ng  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            gen_sec(r != 0, per, ng, int'($urandom_range(200, 300)), int'($urandom_range(30, 120)));
        end

        // Boundary edges after a fresh lock
        @(negedge clk10) reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        for (int s = 0; s < 3; s++) gen_sec(1, 1000, 0, 0, 0);
        #1 check("relock", locked, 1);
        wait_cnt(CLK_HZ - 1 - 3);
        dcf_in = 1'b1; first = -1; nt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk10);
            if (k == 5) dcf_in = 1'b0;
            if (tick) begin nt++; if (first < 0) first = k; end
        end
        check("edge999_tick_count", nt, 1);
        check("edge999_tick_pos", first, 4);
`ifdef DCF_PHASE_ERR_EN
        check("edge999_phase_err", phase_err, -1);
`endif
        wait_cnt(20 - 3);
        dcf_in = 1'b1; nt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk10);
            if (k == 5) dcf_in = 1'b0;
            if (tick) nt++;
        end
        check("edge20_no_tick", nt, 0);
`ifdef DCF_PHASE_ERR_EN
        check("edge20_phase_err", phase_err, 20);
`endif

        // Asynchronous reset while locked
        wait_cnt(600);
        check("locked_before_reset", locked, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_tick", tick, 0);
        check("async_rst_locked", locked, 0);
        check("async_rst_mm", minute_mark, 0);
`ifdef DCF_PHASE_ERR_EN
        check("async_rst_phase_err", phase_err, 0);
`endif
        @(negedge clk10) reset = 1'b0;
        gen_sec(1, 1000, 0, 0, 0);
        gen_sec(1, 1000, 0, 0, 0);
        #1 check("post_reset_hunt", locked, 0);
        gen_sec(1, 1000, 0, 0, 0);
        #1 check("post_reset_lock", locked, 1);
        cycles(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
